// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer family.
package mux_pkg;

  localparam int unsigned RR_N_CH_DEF = 4;
  localparam int unsigned RR_W_DEF    = 8;

  // Index width that never collapses to zero bits, so N_CH=1 still gets a 1-bit port.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping modulo N_CH.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned N_CH  = RR_N_CH_DEF,
  parameter int unsigned SEL_W = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any_gnt
);

  logic [2*N_CH-1:0] w_req_dbl;
  logic [N_CH-1:0]   w_rot;

  // Doubling the request vector turns the wrap-around search into a plain slice.
  assign w_req_dbl = {req, req};
  assign w_rot     = w_req_dbl[ptr +: N_CH];

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    if (en) begin
      // Scan downwards so the lowest rotated position (nearest to ptr) wins last.
      for (int k = int'(N_CH) - 1; k >= 0; k--) begin
        if (w_rot[k]) begin
          idx = int'(ptr) + k;
          if (idx >= int'(N_CH)) idx = idx - int'(N_CH);
          gnt     = N_CH'(1) << idx;
          gnt_idx = SEL_W'(idx);
          any_gnt = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux with round-robin arbitration and a registered output stage.
// Optional feature macro: RR_FORCE_SEL_EN adds force_en/force_sel to pin the grant to one channel.
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter int unsigned N_CH  = RR_N_CH_DEF,
  parameter int unsigned W     = RR_W_DEF,
  parameter int unsigned SEL_W = clog2_min1(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  input  logic              out_ready
`ifdef RR_FORCE_SEL_EN
  ,
  input  logic              force_en,
  input  logic [SEL_W-1:0]  force_sel
`endif
);

  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  logic [SEL_W-1:0] r_out_ch;
  logic [SEL_W-1:0] r_ptr;

  logic             w_accept;
  logic             w_en;
  logic             w_any;
  logic             w_forced;
  logic [N_CH-1:0]  w_req;
  logic [N_CH-1:0]  w_gnt;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic [W-1:0]     w_sel_data;

`ifdef RR_FORCE_SEL_EN
  // An out-of-range force_sel masks every request, so nothing transfers.
  assign w_forced = force_en;
  assign w_req    = !force_en ? in_valid :
                    (int'(force_sel) < int'(N_CH)) ? (in_valid & (N_CH'(1) << force_sel)) : '0;
`else
  assign w_forced = 1'b0;
  assign w_req    = in_valid;
`endif

  assign w_accept = !r_out_valid || out_ready;
  assign w_en     = w_accept && rst_n;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arbiter (
    .req     (w_req),
    .ptr     (r_ptr),
    .en      (w_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any_gnt (w_any)
  );

  assign in_ready  = w_gnt;
  assign w_ptr_nxt = (w_gnt_idx == SEL_W'(N_CH - 1)) ? '0 : w_gnt_idx + 1'b1;

  // AND-OR select keeps X on non-granted lanes from reaching the output register.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      w_sel_data = w_sel_data | (in_data[i*W +: W] & {W{w_gnt[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
    end else if (w_accept) begin
      r_out_valid <= w_any;
      if (w_any) begin
        r_out_data <= w_sel_data;
        r_out_ch   <= w_gnt_idx;
        if (!w_forced) r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux (N_CH=4, W=8): directed table, corner sequences, random vs model.
module tb_rr_stream_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          force_en = 1'b0;
  logic [1:0]    force_sel = '0;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    out_ch;

  int n_cmp = 0;
  int n_err = 0;

  rr_stream_mux #(
    .N_CH (N),
    .W    (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
`ifdef RR_FORCE_SEL_EN
    ,
    .force_en  (force_en),
    .force_sel (force_sel)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: round-robin search from ptr with modular arithmetic.
  logic       m_valid = 1'b0;
  logic [7:0] m_data = '0;
  logic [1:0] m_ch = '0;
  int         m_ptr = 0;
  logic       m_acc;
  logic [3:0] m_g;

  function automatic logic [3:0] m_grant(input logic r, input logic [3:0] v, input logic fe,
                                         input logic [1:0] fs, input int p, input logic acc);
    logic [3:0] g;
    g = '0;
    if (r && acc) begin
      if (fe) begin
        if (v[fs]) g[fs] = 1'b1;
      end else begin
        for (int k = N - 1; k >= 0; k--) begin
          int c;
          c = (p + k) % N;
          if (v[c]) g = 4'(1 << c);
        end
      end
    end
    return g;
  endfunction

  function automatic int m_idx(input logic [3:0] g);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  assign m_acc = !m_valid || out_ready;
  assign m_g   = m_grant(rst_n, in_valid, force_en, force_sel, m_ptr, m_acc);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ch    <= '0;
      m_ptr   <= 0;
    end else if (m_g != 4'b0) begin
      m_valid <= 1'b1;
      m_data  <= in_data[m_idx(m_g)*W +: W];
      m_ch    <= 2'(m_idx(m_g));
      if (!force_en) m_ptr <= (m_idx(m_g) + 1) % N;
    end else if (m_acc) begin
      m_valid <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called 1 time unit after a rising edge: drive, check in_ready mid-cycle, clock, check outputs.
  task automatic step(input string tag, input logic r, input logic [3:0] v, input logic [31:0] d,
                      input logic o, input logic fe, input logic [1:0] fs, input logic [3:0] er,
                      input logic ev, input logic [7:0] ed, input logic [1:0] ec);
    rst_n = r; in_valid = v; in_data = d; out_ready = o; force_en = fe; force_sel = fs;
    #2;
    check({tag, " in_ready"}, 32'(in_ready), 32'(er));
    @(posedge clk);
    #1;
    check({tag, " out_valid"}, 32'(out_valid), 32'(ev));
    check({tag, " out_data"}, 32'(out_data), 32'(ed));
    check({tag, " out_ch"}, 32'(out_ch), 32'(ec));
  endtask

  typedef struct {
    string      tag;
    logic       r;
    logic [3:0] v;
    logic [31:0] d;
    logic       o;
    logic [3:0] er;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] ec;
  } vec_t;

  function automatic vec_t mk(input string tag, input logic r, input logic [3:0] v,
                              input logic [31:0] d, input logic o, input logic [3:0] er,
                              input logic ev, input logic [7:0] ed, input logic [1:0] ec);
    vec_t x;
    x.tag = tag; x.r = r; x.v = v; x.d = d; x.o = o;
    x.er = er; x.ev = ev; x.ed = ed; x.ec = ec;
    return x;
  endfunction

  localparam logic [31:0] D = 32'h13121110;
  localparam logic [31:0] B = 32'h131211A5;

  initial begin
    vec_t tbl[$];
    tbl.push_back(mk("reset0", 1'b0, 4'hF, D, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0));
    tbl.push_back(mk("reset1", 1'b0, 4'hF, D, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0));
    tbl.push_back(mk("rot0", 1'b1, 4'hF, D, 1'b1, 4'h1, 1'b1, 8'h10, 2'd0));
    tbl.push_back(mk("rot1", 1'b1, 4'hF, D, 1'b1, 4'h2, 1'b1, 8'h11, 2'd1));
    tbl.push_back(mk("rot2", 1'b1, 4'hF, D, 1'b1, 4'h4, 1'b1, 8'h12, 2'd2));
    tbl.push_back(mk("rot3", 1'b1, 4'hF, D, 1'b1, 4'h8, 1'b1, 8'h13, 2'd3));
    tbl.push_back(mk("rot4", 1'b1, 4'hF, D, 1'b1, 4'h1, 1'b1, 8'h10, 2'd0));
    tbl.push_back(mk("skip0", 1'b1, 4'hA, D, 1'b1, 4'h2, 1'b1, 8'h11, 2'd1));
    tbl.push_back(mk("skip1", 1'b1, 4'hA, D, 1'b1, 4'h8, 1'b1, 8'h13, 2'd3));
    tbl.push_back(mk("skip2", 1'b1, 4'hA, D, 1'b1, 4'h2, 1'b1, 8'h11, 2'd1));
    tbl.push_back(mk("skip3", 1'b1, 4'hA, D, 1'b1, 4'h8, 1'b1, 8'h13, 2'd3));
    tbl.push_back(mk("bp_load", 1'b1, 4'h1, B, 1'b1, 4'h1, 1'b1, 8'hA5, 2'd0));
    tbl.push_back(mk("bp0", 1'b1, 4'hF, B, 1'b0, 4'h0, 1'b1, 8'hA5, 2'd0));
    tbl.push_back(mk("bp1", 1'b1, 4'hF, B, 1'b0, 4'h0, 1'b1, 8'hA5, 2'd0));
    tbl.push_back(mk("bp2", 1'b1, 4'hF, B, 1'b0, 4'h0, 1'b1, 8'hA5, 2'd0));
    tbl.push_back(mk("bp_rel", 1'b1, 4'hF, B, 1'b1, 4'h2, 1'b1, 8'h11, 2'd1));
    tbl.push_back(mk("drain", 1'b1, 4'h0, D, 1'b1, 4'h0, 1'b0, 8'h11, 2'd1));
    tbl.push_back(mk("idle", 1'b1, 4'h0, D, 1'b0, 4'h0, 1'b0, 8'h11, 2'd1));
    tbl.push_back(mk("refill", 1'b1, 4'h4, D, 1'b0, 4'h4, 1'b1, 8'h12, 2'd2));

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      step(tbl[i].tag, tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].o, 1'b0, 2'd0,
           tbl[i].er, tbl[i].ev, tbl[i].ed, tbl[i].ec);
    end

    // Reset while a word is held, then restart from channel 0.
    step("midrst", 1'b0, 4'hF, D, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 8'h00, 2'd0);
    step("postrst", 1'b1, 4'hF, D, 1'b1, 1'b0, 2'd0, 4'h1, 1'b1, 8'h10, 2'd0);

`ifdef RR_FORCE_SEL_EN
    step("force0", 1'b1, 4'hF, D, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1, 8'h12, 2'd2);
    step("force1", 1'b1, 4'hF, D, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1, 8'h12, 2'd2);
    step("unforce", 1'b1, 4'hF, D, 1'b1, 1'b0, 2'd0, 4'h2, 1'b1, 8'h11, 2'd1);
    step("force_inv", 1'b1, 4'hB, D, 1'b1, 1'b1, 2'd2, 4'h0, 1'b0, 8'h11, 2'd1);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
`ifdef RR_FORCE_SEL_EN
      force_en  = ($urandom_range(0, 4) == 0);
      force_sel = 2'($urandom);
`endif
      #2;
      check("rnd in_ready", 32'(in_ready), 32'(m_g));
      @(posedge clk);
      #1;
      check("rnd out_valid", 32'(out_valid), 32'(m_valid));
      check("rnd out_data", 32'(out_data), 32'(m_data));
      check("rnd out_ch", 32'(out_ch), 32'(m_ch));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
